// File: rtl/final_add_seq_3_2.sv
// rtl/final_add_seq_3_2.sv - sequences a multi-word carry-resolving add through an external pipelined adder
module final_add_seq_3_2 #(
    parameter int NWORDS = 16,
    parameter int AW     = 4,
    parameter int STAGE  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [1:0]    carry_out,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [255:0]  rd_a,
    input  logic [255:0]  rd_b,
    input  logic          rd_ffc,
    output logic [255:0]  add_a,
    output logic [255:0]  add_b,
    output logic          add_ffc,
    input  logic [257:0]  add_sum,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [255:0]  wr_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(NWORDS - 1);

    state_t          state;
    state_t          state_nx;
    logic            accept;
    logic [STAGE:0]  vld;
    logic [AW-1:0]   adr [STAGE+1];
    logic [1:0]      c;
    logic [256:0]    t;
    logic [1:0]      c_next;

    assign accept = (state == IDLE) && start;
    assign rd_en  = (state == ISSUE);
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ISSUE;
            ISSUE:   if (rd_addr == LAST) state_nx = DRAIN;
            DRAIN:   if (wr_en && wr_addr == LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr <= '0;
        end else if (accept) begin
            rd_addr <= '0;
        end else if (state == ISSUE && rd_addr != LAST) begin
            rd_addr <= rd_addr + AW'(1);
        end
    end

    // vld[0]/adr[0] line up with operand RAM data; vld[STAGE]/adr[STAGE] with the adder output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i <= STAGE; i++) begin
                adr[i] <= '0;
            end
        end else begin
            vld    <= {vld[STAGE-1:0], rd_en};
            adr[0] <= rd_addr;
            for (int i = 1; i <= STAGE; i++) begin
                adr[i] <= adr[i-1];
            end
        end
    end

    assign add_a   = vld[0] ? rd_a : '0;
    assign add_b   = vld[0] ? rd_b : '0;
    assign add_ffc = vld[0] ? rd_ffc : 1'b0;

    assign wr_en   = vld[STAGE];
    assign wr_addr = adr[STAGE];

    // inter-word carry is folded into the low 256 bits; its overflow joins the adder's upper bits
    always_comb begin
        t       = {1'b0, add_sum[255:0]} + {255'b0, c};
        c_next  = add_sum[257:256] + {1'b0, t[256]};
        wr_data = t[255:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c         <= '0;
            carry_out <= '0;
        end else begin
            if (accept) begin
                c <= '0;
            end else if (wr_en) begin
                c <= c_next;
            end
            if (wr_en && wr_addr == LAST) begin
                carry_out <= c_next;
            end
        end
    end

endmodule

// File: tb/tb_final_add_seq_3_2.sv
// tb/tb_final_add_seq_3_2.sv - directed bench for final_add_seq_3_2 at STAGE=1 and STAGE=2
module tb_final_add_seq_3_2;

    localparam int N = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [255:0] mem_a   [N];
    logic [255:0] mem_b   [N];
    logic         mem_ffc [N];

    logic [1:0]   busy_v, done_v, rd_en_v, wr_en_v;
    logic [3:0]   rd_addr_v [2];
    logic [3:0]   wr_addr_v [2];
    logic [255:0] wr_data_v [2];
    logic [1:0]   carry_v   [2];

    // Instance g uses an adder of latency g+1, each with its own operand RAM port and adder model
    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [255:0] rd_a, rd_b, add_a, add_b, wr_data;
        logic         rd_ffc, add_ffc, busy, done, rd_en, wr_en;
        logic [3:0]   rd_addr, wr_addr;
        logic [1:0]   carry_out;
        logic [257:0] p1, p2, add_sum;

        final_add_seq_3_2 #(.NWORDS(N), .AW(4), .STAGE(g + 1)) dut (
            .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
            .carry_out(carry_out), .rd_en(rd_en), .rd_addr(rd_addr),
            .rd_a(rd_a), .rd_b(rd_b), .rd_ffc(rd_ffc),
            .add_a(add_a), .add_b(add_b), .add_ffc(add_ffc), .add_sum(add_sum),
            .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
        );

        always @(posedge clk) begin
            if (rd_en) begin
                rd_a   <= mem_a[rd_addr];
                rd_b   <= mem_b[rd_addr];
                rd_ffc <= mem_ffc[rd_addr];
            end
        end

        always @(posedge clk) begin
            p1 <= {2'b00, add_a} + {2'b00, add_b} + {1'b0, add_ffc, 256'b0};
            p2 <= p1;
        end
        assign add_sum = (g == 0) ? p1 : p2;

        assign busy_v[g]    = busy;
        assign done_v[g]    = done;
        assign rd_en_v[g]   = rd_en;
        assign wr_en_v[g]   = wr_en;
        assign rd_addr_v[g] = rd_addr;
        assign wr_addr_v[g] = wr_addr;
        assign wr_data_v[g] = wr_data;
        assign carry_v[g]   = carry_out;
    end

    int n_checks = 0;
    int n_pass   = 0;

    logic [255:0] res [2][N];
    int           nwr   [2];
    int           ndone [2];
    int           dcyc  [2];
    bit           order_bad [2];
    int           scyc;

    logic [255:0] exp_w [N];
    logic [1:0]   exp_c;
    logic [1:0]   exp_hi;

    task automatic build_golden();
        logic [4099:0] tot;
        tot = '0;
        for (int k = 0; k < N; k++) begin
            tot = tot + (4100'(mem_a[k]) << (256 * k)) + (4100'(mem_b[k]) << (256 * k))
                      + (4100'(mem_ffc[k]) << (256 * k + 256));
        end
        for (int k = 0; k < N; k++) exp_w[k] = tot[256*k +: 256];
        exp_c  = tot[4097:4096];
        exp_hi = tot[4099:4098];
    endtask

    task automatic fill_random();
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < 8; j++) begin
                mem_a[k][32*j +: 32] = $urandom;
                mem_b[k][32*j +: 32] = $urandom;
            end
            mem_ffc[k] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic fill_const(input logic [255:0] a, input logic [255:0] b, input logic f);
        for (int k = 0; k < N; k++) begin
            mem_a[k]   = a;
            mem_b[k]   = b;
            mem_ffc[k] = f;
        end
    endtask

    // Pulses (or holds) start and records writes/done per instance, sampling on negedges
    task automatic do_run(input bit hold, input int extra);
        int stop_at;
        for (int g = 0; g < 2; g++) begin
            nwr[g] = 0; ndone[g] = 0; dcyc[g] = -1; order_bad[g] = 1'b0;
        end
        stop_at = -1;
        @(negedge clk);
        start = 1'b1;
        scyc  = cyc;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            start = hold && (ndone[0] == 0);
            for (int g = 0; g < 2; g++) begin
                if (wr_en_v[g]) begin
                    if (wr_addr_v[g] != nwr[g][3:0]) order_bad[g] = 1'b1;
                    res[g][wr_addr_v[g]] = wr_data_v[g];
                    nwr[g]++;
                end
                if (done_v[g]) begin
                    ndone[g]++;
                    dcyc[g] = cyc;
                end
            end
            if (ndone[1] != 0 && stop_at < 0) stop_at = i + extra;
            if (stop_at >= 0 && i >= stop_at) break;
        end
        start = 1'b0;
        for (int g = 0; g < 2; g++) begin
            n_checks++;
            if (ndone[g] == 0 || order_bad[g])
                $display("FAIL run_completion[%0d]: done=%0d order_bad=%0d required done>0 in-order writes", g, ndone[g], order_bad[g]);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            n_checks++;
            if ({busy_v[g], done_v[g], rd_en_v[g], wr_en_v[g]} !== 4'b0)
                $display("FAIL reset_strobes[%0d]: got %b required 0000", g, {busy_v[g], done_v[g], rd_en_v[g], wr_en_v[g]});
            else n_pass++;
            n_checks++;
            if ({carry_v[g], rd_addr_v[g], wr_addr_v[g]} !== 10'b0)
                $display("FAIL reset_values[%0d]: got %h required 0", g, {carry_v[g], rd_addr_v[g], wr_addr_v[g]});
            else n_pass++;
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ones_plus_one();
        fill_const({256{1'b1}}, 256'd0, 1'b0);
        mem_b[0] = 256'd1;
        do_run(1'b0, 0);
        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < N; k++) begin
                n_checks++;
                if (res[g][k] !== 256'd0)
                    $display("FAIL ones_word[%0d][%0d]: got %h required 0", g, k, res[g][k]);
                else n_pass++;
            end
            n_checks++;
            if (carry_v[g] !== 2'd1) $display("FAIL ones_carry[%0d]: got %0d required 1", g, carry_v[g]);
            else n_pass++;
            n_checks++;
            if (dcyc[g] - scyc + 1 != N + g + 1 + 3)
                $display("FAIL ones_latency[%0d]: got %0d required %0d", g, dcyc[g] - scyc + 1, N + g + 4);
            else n_pass++;
        end
    endtask

    task automatic test_max_operands();
        fill_const({256{1'b1}}, {256{1'b1}}, 1'b1);
        build_golden();
        do_run(1'b0, 0);
        n_checks++;
        if (exp_hi !== 2'b00) $display("FAIL max_overflow: got %b required 00", exp_hi);
        else n_pass++;
        for (int g = 0; g < 2; g++) begin
            n_checks++;
            if (res[g][0] !== {{255{1'b1}}, 1'b0})
                $display("FAIL max_word0[%0d]: got %h required 2^256-2", g, res[g][0]);
            else n_pass++;
            for (int k = 1; k < N; k++) begin
                n_checks++;
                if (res[g][k] !== exp_w[k])
                    $display("FAIL max_word[%0d][%0d]: got %h required %h", g, k, res[g][k], exp_w[k]);
                else n_pass++;
            end
            n_checks++;
            if (carry_v[g] !== exp_c) $display("FAIL max_carry[%0d]: got %0d required %0d", g, carry_v[g], exp_c);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            fill_random();
            build_golden();
            do_run(1'b0, 2);
            for (int g = 0; g < 2; g++) begin
                for (int k = 0; k < N; k++) begin
                    n_checks++;
                    if (res[g][k] !== exp_w[k])
                        $display("FAIL rand_word[%0d][%0d][%0d]: got %h required %h", r, g, k, res[g][k], exp_w[k]);
                    else n_pass++;
                end
                n_checks++;
                if (carry_v[g] !== exp_c) $display("FAIL rand_carry[%0d][%0d]: got %0d required %0d", r, g, carry_v[g], exp_c);
                else n_pass++;
            end
        end
    endtask

    task automatic test_start_held();
        fill_random();
        build_golden();
        do_run(1'b1, 20);
        for (int g = 0; g < 2; g++) begin
            n_checks++;
            if (nwr[g] != N) $display("FAIL held_writes[%0d]: got %0d required %0d", g, nwr[g], N);
            else n_pass++;
            n_checks++;
            if (ndone[g] != 1) $display("FAIL held_dones[%0d]: got %0d required 1", g, ndone[g]);
            else n_pass++;
            n_checks++;
            if (res[g][N-1] !== exp_w[N-1] || carry_v[g] !== exp_c)
                $display("FAIL held_result[%0d]: got %h/%0d required %h/%0d", g, res[g][N-1], carry_v[g], exp_w[N-1], exp_c);
            else n_pass++;
        end
    endtask

    task automatic test_abort();
        bit hit;
        int nw;
        fill_const({256{1'b1}}, {256{1'b1}}, 1'b1);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (rd_en_v[0] && rd_addr_v[0] == 4'd5) hit = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!hit) $display("FAIL abort_reach_word5: got none required rd_addr 5 within 40 cycles");
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy_v, wr_en_v, rd_en_v} !== 6'b0)
            $display("FAIL abort_outputs: got %b required 000000", {busy_v, wr_en_v, rd_en_v});
        else n_pass++;
        nw = 0;
        repeat (3) begin
            @(negedge clk);
            nw += int'(wr_en_v[0]) + int'(wr_en_v[1]);
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            nw += int'(wr_en_v[0]) + int'(wr_en_v[1]);
        end
        n_checks++;
        if (nw != 0) $display("FAIL abort_no_writes: got %0d required 0", nw);
        else n_pass++;
        for (int k = 0; k < N; k++) begin
            mem_a[k] = 256'(k + 1); mem_b[k] = 256'(2 * k); mem_ffc[k] = 1'b0;
        end
        do_run(1'b0, 0);
        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < N; k++) begin
                n_checks++;
                if (res[g][k] !== 256'(3 * k + 1))
                    $display("FAIL abort_rerun_word[%0d][%0d]: got %h required %0d", g, k, res[g][k], 3 * k + 1);
                else n_pass++;
            end
            n_checks++;
            if (carry_v[g] !== 2'd0) $display("FAIL abort_rerun_carry[%0d]: got %0d required 0", g, carry_v[g]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        fill_const({256{1'b1}}, {256{1'b1}}, 1'b1);
        do_run(1'b0, 0);
        fill_const({256{1'b1}}, 256'd0, 1'b0);
        do_run(1'b0, 0);
        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < N; k++) begin
                n_checks++;
                if (res[g][k] !== {256{1'b1}})
                    $display("FAIL b2b_word[%0d][%0d]: got %h required all ones", g, k, res[g][k]);
                else n_pass++;
            end
            n_checks++;
            if (carry_v[g] !== 2'd0) $display("FAIL b2b_carry[%0d]: got %0d required 0", g, carry_v[g]);
            else n_pass++;
            n_checks++;
            if (nwr[g] != N || ndone[g] != 1)
                $display("FAIL b2b_counts[%0d]: got %0d writes %0d dones required %0d/1", g, nwr[g], ndone[g], N);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_ones_plus_one();
        test_max_operands();
        test_random();
        test_start_held();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
